// File: rtl/dmem_mmio_if.sv
// MEM-stage data-memory port between the CPU pipeline and the data-memory slave.
// The master drives address/data/strobes; the slave returns combinational read data.
interface dmem_mmio_if;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;

  modport master (
    output dmemaddr,
    output dmemwdata,
    output dmemwrite,
    output dmemread,
    input  dmemrdata
  );

  modport slave (
    input  dmemaddr,
    input  dmemwdata,
    input  dmemwrite,
    input  dmemread,
    output dmemrdata
  );
endinterface

// File: rtl/dmem_mmio.sv
// Data-memory slave: word-addressed RAM plus an I/O page with LEDs, synchronized
// switches and a free-running timer with compare and sticky match flag.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS = 128,
  parameter logic [15:0] IO_BASE   = 16'hFF00
) (
  input  logic       clock,
  input  logic       reset,
  dmem_mmio_if.slave bus,
  input  logic [3:0] switches,
  output logic [7:0] leds,
  output logic       timer_irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  localparam logic [2:0] RegLed    = 3'd0;
  localparam logic [2:0] RegSw     = 3'd1;
  localparam logic [2:0] RegTcount = 3'd2;
  localparam logic [2:0] RegTcmp   = 3'd3;
  localparam logic [2:0] RegStatus = 3'd4;

  logic [14:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic [2:0]    io_off;
  logic          ram_sel;
  logic          io_sel;
  logic          unused_addr;

  assign word_addr   = bus.dmemaddr[15:1];
  assign ram_idx     = word_addr[AW-1:0];
  assign io_off      = bus.dmemaddr[3:1];
  assign unused_addr = bus.dmemaddr[0];

  // RAM decode takes priority over the I/O page when the ranges overlap.
  assign ram_sel = ({17'd0, word_addr} < RAM_WORDS);
  assign io_sel  = !ram_sel && (bus.dmemaddr[15:4] == IO_BASE[15:4]);

  logic we_ram;
  logic we_led;
  logic we_tcount;
  logic we_tcmp;
  logic we_status;

  assign we_ram    = bus.dmemwrite && ram_sel;
  assign we_led    = bus.dmemwrite && io_sel && (io_off == RegLed);
  assign we_tcount = bus.dmemwrite && io_sel && (io_off == RegTcount);
  assign we_tcmp   = bus.dmemwrite && io_sel && (io_off == RegTcmp);
  assign we_status = bus.dmemwrite && io_sel && (io_off == RegStatus);

  // RAM has no reset so it maps onto block RAM.
  logic [15:0] ram_q [RAM_WORDS];

  always_ff @(posedge clock) begin
    if (we_ram) begin
      ram_q[ram_idx] <= bus.dmemwdata;
    end
  end

  logic [7:0]  led_q;
  logic [3:0]  sw_meta_q;
  logic [3:0]  sw_sync_q;
  logic [15:0] count_q, count_d;
  logic [15:0] tcmp_q;
  logic        flag_q, flag_d;
  logic        match;

  assign match = (count_q == tcmp_q);

  always_comb begin
    count_d = count_q + 16'd1;
    if (we_tcount) begin
      count_d = 16'd0;
    end
  end

  // A match at the same edge as a clear keeps the flag set.
  always_comb begin
    flag_d = flag_q;
    if (we_status && bus.dmemwdata[0]) begin
      flag_d = 1'b0;
    end
    if (match) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q     <= 8'h00;
      sw_meta_q <= 4'h0;
      sw_sync_q <= 4'h0;
      count_q   <= 16'h0000;
      tcmp_q    <= 16'hFFFF;
      flag_q    <= 1'b0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      count_q   <= count_d;
      flag_q    <= flag_d;
      if (we_led) begin
        led_q <= bus.dmemwdata[7:0];
      end
      if (we_tcmp) begin
        tcmp_q <= bus.dmemwdata;
      end
    end
  end

  assign leds      = led_q;
  assign timer_irq = flag_q;

  always_comb begin
    bus.dmemrdata = 16'h0000;
    if (bus.dmemread) begin
      if (ram_sel) begin
        bus.dmemrdata = ram_q[ram_idx];
      end else if (io_sel) begin
        case (io_off)
          RegLed:    bus.dmemrdata = {8'h00, led_q};
          RegSw:     bus.dmemrdata = {12'h000, sw_sync_q};
          RegTcount: bus.dmemrdata = count_q;
          RegTcmp:   bus.dmemrdata = tcmp_q;
          RegStatus: bus.dmemrdata = {15'h0000, flag_q};
          default:   bus.dmemrdata = 16'h0000;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, I/O page, switch sync, timer, reset.
module tb_dmem_mmio;
  logic       clock;
  logic       reset;
  logic [3:0] switches;
  logic [7:0] leds;
  logic       timer_irq;

  int errors = 0;
  int checks = 0;

  dmem_mmio_if bus ();

  dmem_mmio #(
    .RAM_WORDS(128),
    .IO_BASE  (16'hFF00)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .switches (switches),
    .leds     (leds),
    .timer_irq(timer_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single write cycle; returns 1ns after the committing edge.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    bus.dmemaddr  = a;
    bus.dmemwdata = d;
    bus.dmemwrite = 1'b1;
    @(posedge clock);
    #1;
    bus.dmemwrite = 1'b0;
  endtask

  // Combinational read, completes within 1ns and does not cross an edge.
  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    bus.dmemaddr = a;
    bus.dmemread = 1'b1;
    #1;
    d = bus.dmemrdata;
    bus.dmemread = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset = 1'b1;
    #2;
    checks++;
    if (leds !== 8'h00) begin
      errors++; $display("FAIL reset_leds got %h want 00", leds);
    end
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq got %b want 0", timer_irq);
    end
    checks++;
    if (bus.dmemrdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata_idle got %h want 0000", bus.dmemrdata);
    end
    bus_read(16'hFF06, d);
    checks++;
    if (d !== 16'hFFFF) begin
      errors++; $display("FAIL reset_tcmp got %h want ffff", d);
    end
    bus_read(16'hFF04, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL reset_tcount got %h want 0000", d);
    end
    bus_read(16'hFF02, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL reset_sw got %h want 0000", d);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_ram();
    logic [15:0] d;
    bus_write(16'h0010, 16'hBEEF);
    bus_read(16'h0010, d);
    checks++;
    if (d !== 16'hBEEF) begin
      errors++; $display("FAIL ram_read got %h want beef", d);
    end
    bus_read(16'h0011, d);
    checks++;
    if (d !== 16'hBEEF) begin
      errors++; $display("FAIL ram_odd_addr got %h want beef", d);
    end
    bus.dmemaddr = 16'h0010;
    #1;
    checks++;
    if (bus.dmemrdata !== 16'h0000) begin
      errors++; $display("FAIL ram_noread got %h want 0000", bus.dmemrdata);
    end
    // Top RAM word and first word past RAM
    bus_write(16'h00FE, 16'h5A5A);
    bus_write(16'h0100, 16'h7777);
    bus_read(16'h00FE, d);
    checks++;
    if (d !== 16'h5A5A) begin
      errors++; $display("FAIL ram_top got %h want 5a5a", d);
    end
    bus_read(16'h0100, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL ram_past_end got %h want 0000", d);
    end
  endtask

  task automatic test_same_cycle_rw();
    bus_write(16'h0020, 16'h1111);
    @(negedge clock);
    bus.dmemaddr  = 16'h0020;
    bus.dmemwdata = 16'h2222;
    bus.dmemwrite = 1'b1;
    bus.dmemread  = 1'b1;
    #1;
    checks++;
    if (bus.dmemrdata !== 16'h1111) begin
      errors++; $display("FAIL rw_old got %h want 1111", bus.dmemrdata);
    end
    @(posedge clock);
    #1;
    bus.dmemwrite = 1'b0;
    #1;
    checks++;
    if (bus.dmemrdata !== 16'h2222) begin
      errors++; $display("FAIL rw_new got %h want 2222", bus.dmemrdata);
    end
    bus.dmemread = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'hA001;
    exp_d[1] = 16'hB002;
    exp_d[2] = 16'hC003;
    @(negedge clock);
    bus.dmemwrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.dmemaddr  = 16'h0030 + 16'(2 * i);
      bus.dmemwdata = exp_d[i];
      @(negedge clock);
    end
    bus.dmemwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_read(16'h0030 + 16'(2 * i), d);
      checks++;
      if (d !== exp_d[i]) begin
        errors++; $display("FAIL b2b_word%0d got %h want %h", i, d, exp_d[i]);
      end
    end
  endtask

  task automatic test_led_unmapped();
    logic [15:0] d;
    bus_write(16'hFF00, 16'h12A5);
    checks++;
    if (leds !== 8'hA5) begin
      errors++; $display("FAIL led_out got %h want a5", leds);
    end
    bus_read(16'hFF00, d);
    checks++;
    if (d !== 16'h00A5) begin
      errors++; $display("FAIL led_read got %h want 00a5", d);
    end
    bus_write(16'h8000, 16'h1234);
    checks++;
    if (leds !== 8'hA5) begin
      errors++; $display("FAIL unmapped_led got %h want a5", leds);
    end
    bus_read(16'h8000, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL unmapped_read got %h want 0000", d);
    end
    bus_write(16'hFF0A, 16'hFFFF);
    bus_read(16'hFF0A, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL reserved_read got %h want 0000", d);
    end
  endtask

  task automatic test_switch_sync();
    logic [15:0] d;
    @(posedge clock);
    #1;
    switches = 4'b1010;
    @(posedge clock);
    #1;
    bus_read(16'hFF02, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL sw_edge1 got %h want 0000", d);
    end
    @(posedge clock);
    #1;
    bus_read(16'hFF02, d);
    checks++;
    if (d !== 16'h000A) begin
      errors++; $display("FAIL sw_edge2 got %h want 000a", d);
    end
  endtask

  task automatic test_timer();
    logic [15:0] d;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus_write(16'hFF06, 16'd5);
    bus_write(16'hFF04, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clock);
      #1;
      bus_read(16'hFF04, d);
      checks++;
      if (d !== 16'(i) || timer_irq !== 1'b0) begin
        errors++; $display("FAIL timer_count%0d got %h/%b want %h/0", i, d, timer_irq, 16'(i));
      end
    end
    @(posedge clock);
    #1;
    bus_read(16'hFF04, d);
    checks++;
    if (timer_irq !== 1'b1 || d !== 16'd6) begin
      errors++; $display("FAIL timer_match got irq=%b count=%h want 1/0006", timer_irq, d);
    end
    bus_read(16'hFF08, d);
    checks++;
    if (d !== 16'h0001) begin
      errors++; $display("FAIL status_read got %h want 0001", d);
    end
    bus_write(16'hFF08, 16'h0000);
    checks++;
    if (timer_irq !== 1'b1) begin
      errors++; $display("FAIL status_write0 got %b want 1", timer_irq);
    end
    // Restart count so the clear lands on the edge where count == 5
    bus_write(16'hFF04, 16'h0000);
    repeat (5) @(posedge clock);
    bus_write(16'hFF08, 16'h0001);
    checks++;
    if (timer_irq !== 1'b1) begin
      errors++; $display("FAIL set_wins got %b want 1", timer_irq);
    end
    bus_write(16'hFF08, 16'h0001);
    checks++;
    if (timer_irq !== 1'b0) begin
      errors++; $display("FAIL status_clear got %b want 0", timer_irq);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    bus_write(16'hFF00, 16'h00FF);
    bus_write(16'hFF06, 16'd10);
    bus_write(16'hFF04, 16'h0000);
    repeat (300) @(posedge clock);
    #3;
    bus_read(16'hFF04, d);
    checks++;
    if (d !== 16'd300 || leds !== 8'hFF || timer_irq !== 1'b1) begin
      errors++; $display("FAIL pre_reset got count=%h leds=%h irq=%b want 012c/ff/1", d, leds,
                         timer_irq);
    end
    reset = 1'b1;
    #1;
    bus_read(16'hFF04, d);
    checks++;
    if (leds !== 8'h00 || timer_irq !== 1'b0 || d !== 16'h0000) begin
      errors++; $display("FAIL async_reset got leds=%h irq=%b count=%h want 00/0/0000", leds,
                         timer_irq, d);
    end
    @(negedge clock);
    reset = 1'b0;
    bus_read(16'hFF06, d);
    checks++;
    if (d !== 16'hFFFF) begin
      errors++; $display("FAIL post_reset_tcmp got %h want ffff", d);
    end
    bus_read(16'h0010, d);
    checks++;
    if (d !== 16'hBEEF) begin
      errors++; $display("FAIL ram_kept got %h want beef", d);
    end
  endtask

  initial begin
    reset         = 1'b1;
    switches      = 4'b0000;
    bus.dmemaddr  = 16'h0000;
    bus.dmemwdata = 16'h0000;
    bus.dmemwrite = 1'b0;
    bus.dmemread  = 1'b0;
    test_reset();
    test_ram();
    test_same_cycle_rw();
    test_back_to_back();
    test_led_unmapped();
    test_switch_sync();
    test_timer();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
